// File: rtl/tl_test_indicator_master_if.sv
// -----------------------------------------------------------------------------
// tl_test_indicator_master_if
// Bundles the status-report request/response signals and the TL-UL A/D
// channels of the test-indicator master.
//   master modport : the indicator master (drives req_ready, channel A,
//                    d_ready and the rsp_* completion report)
//   slave  modport : the environment (request source plus TL-UL responder)
//
// Handshake rule for every valid/ready pair in this bundle: a beat transfers
// on a rising clock edge where valid and ready are both 1; while valid is
// high and ready is low the sender keeps valid and payload unchanged.
// rsp_valid has no ready: it is a one-cycle completion pulse.
// -----------------------------------------------------------------------------
interface tl_test_indicator_master_if;
  // Status-report request
  logic        req_valid;
  logic        req_ready;
  logic        req_read;
  logic [31:0] req_data;
  // TL-UL channel A
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [1:0]  a_size;
  logic        a_source;
  logic [14:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  // TL-UL channel D
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [1:0]  d_size;
  logic        d_source;
  logic        d_denied;
  logic [31:0] d_data;
  logic        d_corrupt;
  // Completion report
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        rsp_timeout;

  modport master (
    input  req_valid, req_read, req_data,
    output req_ready,
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
    output d_ready,
    output rsp_valid, rsp_data, rsp_error, rsp_timeout
  );

  modport slave (
    output req_valid, req_read, req_data,
    input  req_ready,
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
    input  d_ready,
    input  rsp_valid, rsp_data, rsp_error, rsp_timeout
  );
endinterface

// File: rtl/tl_test_indicator_master.sv
// -----------------------------------------------------------------------------
// tl_test_indicator_master
// Issues a single TL-UL PutFullData or Get to the test-indicator register for
// each accepted status-report request, waits (bounded) for the D response and
// reports the outcome as a one-cycle completion pulse.
//   clk_i          : sole clock, rising edge
//   rst_i          : asynchronous, active-high reset
//   bus            : request, TL-UL A/D channels and completion report
//   unexpected_d_o : sticky, a D beat arrived with nothing outstanding
//   state_o        : current FSM state (IDLE=0, A_SEND=1, D_WAIT=2, RESP=3)
// -----------------------------------------------------------------------------
module tl_test_indicator_master #(
  parameter logic [14:0] INDICATOR_ADDR = 15'h4000,
  parameter int unsigned TIMEOUT        = 1023
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  tl_test_indicator_master_if.master     bus,
  output logic                           unexpected_d_o,
  output logic [1:0]                     state_o
);

  typedef enum logic [1:0] {IDLE, A_SEND, D_WAIT, RESP} state_e;

  localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

  state_e      state_q, state_d;
  logic        read_q, read_d;
  logic [31:0] data_q, data_d;
  logic        src_q, src_d;       // tag for the next A beat
  logic        tag_q, tag_d;       // tag of the outstanding A beat
  logic [9:0]  cnt_q, cnt_d;
  logic        unexp_q, unexp_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_to_q, rsp_to_d;

  logic        a_fire;
  logic        d_fire;
  logic        exp_tag;
  logic        d_err;
  logic        unused_d_param;

  // D is always sunk, so any d_valid is a fire.
  assign d_fire = bus.d_valid;
  assign a_fire = (state_q == A_SEND) && bus.a_ready;

  // A response landing in the same cycle as the A fire must be matched
  // against the tag being sent now, not the previous outstanding one.
  assign exp_tag = (state_q == A_SEND) ? src_q : tag_q;

  assign d_err = (bus.d_opcode != (read_q ? 3'd1 : 3'd0)) ||
                 (bus.d_source != exp_tag) ||
                 bus.d_denied ||
                 (bus.d_corrupt && read_q) ||
                 (bus.d_size != 2'd2);

  assign unused_d_param = ^bus.d_param;

  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    data_d     = data_q;
    src_d      = src_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    unexp_d    = unexp_q;
    rsp_data_d = 32'd0;
    rsp_err_d  = 1'b0;
    rsp_to_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_fire) unexp_d = 1'b1;
        if (bus.req_valid) begin
          read_d  = bus.req_read;
          data_d  = bus.req_read ? 32'd0 : bus.req_data;
          state_d = A_SEND;
        end
      end
      A_SEND: begin
        if (a_fire) begin
          src_d = ~src_q;
          tag_d = src_q;
          cnt_d = 10'd0;
          if (d_fire) begin
            state_d    = RESP;
            rsp_data_d = read_q ? bus.d_data : 32'd0;
            rsp_err_d  = d_err;
          end else begin
            state_d = D_WAIT;
          end
        end else if (d_fire) begin
          unexp_d = 1'b1;
        end
      end
      D_WAIT: begin
        if (d_fire) begin
          state_d    = RESP;
          rsp_data_d = read_q ? bus.d_data : 32'd0;
          rsp_err_d  = d_err;
        end else if (10'(cnt_q + 10'd1) == TIMEOUT_CNT) begin
          // TIMEOUT full cycles in D_WAIT without a response
          state_d   = RESP;
          rsp_err_d = 1'b1;
          rsp_to_d  = 1'b1;
        end else begin
          cnt_d = 10'(cnt_q + 10'd1);
        end
      end
      RESP: begin
        if (d_fire) unexp_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      read_q     <= 1'b0;
      data_q     <= 32'd0;
      src_q      <= 1'b0;
      tag_q      <= 1'b0;
      cnt_q      <= 10'd0;
      unexp_q    <= 1'b0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 1'b0;
      rsp_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      data_q     <= data_d;
      src_q      <= src_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      unexp_q    <= unexp_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      rsp_to_q   <= rsp_to_d;
    end
  end

  // Payload comes only from registers that change in IDLE, so it is stable
  // for the whole A_SEND stall.
  assign bus.req_ready   = (state_q == IDLE);
  assign bus.a_valid     = (state_q == A_SEND);
  assign bus.a_opcode    = read_q ? 3'd4 : 3'd0;
  assign bus.a_param     = 3'd0;
  assign bus.a_size      = 2'd2;
  assign bus.a_source    = src_q;
  assign bus.a_address   = INDICATOR_ADDR;
  assign bus.a_mask      = 4'hF;
  assign bus.a_data      = data_q;
  assign bus.d_ready     = 1'b1;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_error   = rsp_err_q;
  assign bus.rsp_timeout = rsp_to_q;
  assign unexpected_d_o  = unexp_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_tl_test_indicator_master.sv
module tb_tl_test_indicator_master;

  localparam int TIMEOUT = 1023;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tl_test_indicator_master_if bus();
  logic       unexpected_d;
  logic [1:0] state;

  tl_test_indicator_master #(.INDICATOR_ADDR(15'h4000), .TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus),
    .unexpected_d_o (unexpected_d),
    .state_o        (state)
  );

  int   tests = 0;
  int   fails = 0;
  logic exp_tag;

  typedef struct {
    logic        read;
    logic [31:0] data;
    int          a_wait;
    logic        same;
    int          d_delay;
    logic [2:0]  d_opcode;
    logic        src_flip;
    logic        denied;
    logic        corrupt;
    logic [1:0]  d_size;
    logic [31:0] d_data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid = 1'b0;
    bus.req_read  = 1'b0;
    bus.req_data  = 32'd0;
    bus.a_ready   = 1'b0;
    bus.d_valid   = 1'b0;
    bus.d_opcode  = 3'd0;
    bus.d_param   = 2'd0;
    bus.d_size    = 2'd2;
    bus.d_source  = 1'b0;
    bus.d_denied  = 1'b0;
    bus.d_data    = 32'd0;
    bus.d_corrupt = 1'b0;
  endtask

  task automatic drive_d(input logic [2:0] op, input logic src, input logic den,
                         input logic cor, input logic [1:0] sz, input logic [31:0] dat);
    bus.d_valid   = 1'b1;
    bus.d_opcode  = op;
    bus.d_source  = src;
    bus.d_denied  = den;
    bus.d_corrupt = cor;
    bus.d_size    = sz;
    bus.d_data    = dat;
  endtask

  task automatic check_a(input string name, input logic rd, input logic [31:0] wdata);
    logic [31:0] exp_hdr;
    exp_hdr = {4'b0, (rd ? 3'd4 : 3'd0), 3'd0, 2'd2, exp_tag, 15'h4000, 4'hF};
    check({name, "_a_valid"}, {31'd0, bus.a_valid}, 32'd1);
    check({name, "_a_hdr"}, {4'b0, bus.a_opcode, bus.a_param, bus.a_size, bus.a_source,
                             bus.a_address, bus.a_mask}, exp_hdr);
    check({name, "_a_data"}, bus.a_data, rd ? 32'd0 : wdata);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    exp_tag = 1'b0;
    tick();
  endtask

  // ---------------- driver: one full transaction ----------------
  task automatic run_txn(input vec_t v, input string name);
    logic out_tag;
    check({name, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_read  = v.read;
    bus.req_data  = v.data;
    tick();
    bus.req_valid = 1'b0;
    bus.req_data  = 32'hFFFF_FFFF;   // latched copy must not follow the input
    check({name, "_busy"}, {31'd0, bus.req_ready}, 32'd0);
    for (int k = 0; k < v.a_wait; k++) begin
      bus.a_ready = 1'b0;
      check_a({name, "_stall"}, v.read, v.data);
      tick();
    end
    bus.a_ready = 1'b1;
    check_a(name, v.read, v.data);
    out_tag = exp_tag;
    if (v.same)
      drive_d(v.d_opcode, out_tag ^ v.src_flip, v.denied, v.corrupt, v.d_size, v.d_data);
    tick();
    bus.a_ready = 1'b0;
    exp_tag = ~exp_tag;
    if (!v.same) begin
      for (int k = 0; k < v.d_delay; k++) begin
        check({name, "_wait_rsp"}, {31'd0, bus.rsp_valid}, 32'd0);
        tick();
      end
      drive_d(v.d_opcode, out_tag ^ v.src_flip, v.denied, v.corrupt, v.d_size, v.d_data);
      tick();
    end
    bus.d_valid = 1'b0;
    check({name, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    check({name, "_rsp_data"}, bus.rsp_data, v.exp_data);
    check({name, "_rsp_error"}, {31'd0, bus.rsp_error}, {31'd0, v.exp_err});
    check({name, "_rsp_timeout"}, {31'd0, bus.rsp_timeout}, 32'd0);
    tick();
    check({name, "_rsp_drop"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({name, "_rsp_data_zero"}, bus.rsp_data, 32'd0);
    check({name, "_idle_again"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  // ---------------- test ----------------
  initial begin
    //          read  data          aw  same dly op    flip den  cor  sz     d_data        exp_data      err
    vecs[0]  = '{1'b0, 32'h0000_5555, 0, 1'b0, 3, 3'd0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0,         32'h0,         1'b0};
    vecs[1]  = '{1'b1, 32'h7777_7777, 5, 1'b0, 2, 3'd1, 1'b0, 1'b0, 1'b0, 2'd2, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    vecs[2]  = '{1'b0, 32'hA5A5_A5A5, 0, 1'b0, 1, 3'd0, 1'b0, 1'b1, 1'b0, 2'd2, 32'hDEAD_BEEF, 32'h0,         1'b1};
    vecs[3]  = '{1'b0, 32'h0000_0001, 1, 1'b0, 0, 3'd0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0,         32'h0,         1'b1};
    vecs[4]  = '{1'b1, 32'h0,         0, 1'b1, 0, 3'd1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[5]  = '{1'b1, 32'h0,         2, 1'b0, 4, 3'd1, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF, 0, 1'b0, 2, 3'd1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0,         32'h0,         1'b1};
    vecs[7]  = '{1'b1, 32'h0,         0, 1'b0, 0, 3'd1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h1111_2222, 32'h1111_2222, 1'b1};
    vecs[8]  = '{1'b0, 32'h0F0F_0F0F, 3, 1'b1, 0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0,         32'h0,         1'b0};
    vecs[9]  = '{1'b1, 32'h0,         0, 1'b0, 0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0000_0005, 32'h0000_0005, 1'b1};
    vecs[10] = '{1'b0, 32'h3C3C_3C3C, 0, 1'b0, 1, 3'd0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0,         32'h0,         1'b0};

    clear_inputs();
    exp_tag = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    // reset state
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_a_valid", {31'd0, bus.a_valid}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_bits", {bus.rsp_data[29:0], bus.rsp_error, bus.rsp_timeout}, 32'd0);
    check("rst_a_source", {31'd0, bus.a_source}, 32'd0);
    check("rst_a_data", bus.a_data, 32'd0);
    check("rst_unexp", {31'd0, unexpected_d}, 32'd0);
    check("rst_d_ready", {31'd0, bus.d_ready}, 32'd1);
    check("rst_state", {30'd0, state}, 32'd0);
    rst = 1'b0;
    tick();

    // table-driven transactions
    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i], $sformatf("v%0d", i));
      tick();
    end
    check("table_no_unexp", {31'd0, unexpected_d}, 32'd0);

    // D beat while idle
    drive_d(3'd0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0);
    tick();
    bus.d_valid = 1'b0;
    check("idle_d_unexp", {31'd0, unexpected_d}, 32'd1);
    check("idle_d_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    check("idle_d_state", {30'd0, state}, 32'd0);
    tick();
    check("idle_d_sticky", {31'd0, unexpected_d}, 32'd1);
    check("idle_d_no_rsp2", {31'd0, bus.rsp_valid}, 32'd0);

    do_reset();
    check("reset_clears_unexp", {31'd0, unexpected_d}, 32'd0);
    check("reset_clears_src", {31'd0, bus.a_source}, 32'd0);

    // timeout, then a late D beat
    begin
      int early;
      early = 0;
      bus.req_valid = 1'b1;
      bus.req_read  = 1'b0;
      bus.req_data  = 32'h5A5A_5A5A;
      tick();
      bus.req_valid = 1'b0;
      bus.a_ready   = 1'b1;
      check_a("to", 1'b0, 32'h5A5A_5A5A);
      tick();
      bus.a_ready = 1'b0;
      exp_tag = ~exp_tag;
      for (int k = 0; k < TIMEOUT - 1; k++) begin
        if (bus.rsp_valid !== 1'b0) early++;
        tick();
      end
      check("to_no_early_rsp", early, 32'd0);
      tick();
      check("to_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("to_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd1);
      check("to_rsp_error", {31'd0, bus.rsp_error}, 32'd1);
      check("to_rsp_data", bus.rsp_data, 32'd0);
      check("to_no_unexp_yet", {31'd0, unexpected_d}, 32'd0);
      tick();
      check("to_idle", {31'd0, bus.req_ready}, 32'd1);
      check("to_rsp_timeout_clr", {31'd0, bus.rsp_timeout}, 32'd0);
      drive_d(3'd0, ~exp_tag, 1'b0, 1'b0, 2'd2, 32'h0);
      tick();
      bus.d_valid = 1'b0;
      check("to_late_d_unexp", {31'd0, unexpected_d}, 32'd1);
      check("to_late_d_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end

    // reset pulse in the middle of D_WAIT
    do_reset();
    begin
      int stray;
      stray = 0;
      bus.req_valid = 1'b1;
      bus.req_read  = 1'b0;
      bus.req_data  = 32'h1357_9BDF;
      tick();
      bus.req_valid = 1'b0;
      bus.a_ready   = 1'b1;
      tick();
      bus.a_ready = 1'b0;
      check("mid_state_dwait", {30'd0, state}, 32'd2);
      check("mid_src_toggled", {31'd0, bus.a_source}, 32'd1);
      tick();
      rst = 1'b1;
      #1;
      check("mid_async_state", {30'd0, state}, 32'd0);
      check("mid_async_src", {31'd0, bus.a_source}, 32'd0);
      check("mid_async_a_data", bus.a_data, 32'd0);
      check("mid_async_a_valid", {31'd0, bus.a_valid}, 32'd0);
      check("mid_async_d_ready", {31'd0, bus.d_ready}, 32'd1);
      tick();
      rst = 1'b0;
      exp_tag = 1'b0;
      check("mid_release_ready", {31'd0, bus.req_ready}, 32'd1);
      check("mid_release_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      for (int k = 0; k < 5; k++) begin
        tick();
        if (bus.rsp_valid !== 1'b0) stray++;
      end
      check("mid_no_stray_rsp", stray, 32'd0);
      run_txn(vecs[1], "post_reset");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
